acc_bank: RTL and testbench
===========================

Name: acc_bank

Overview:
- Parametrised multi-accumulator bank; successor to the single 16-bit accumulator.
- Holds NUM_ACC accumulators of WIDTH bits.
- Supports load from the data bus or ALU, increment/decrement with wrap or saturate, clear, and a multi-cycle serial shift with busy/done handshake.
- Sits between the datapath bus/ALU and the control unit; the control unit selects the target accumulator per cycle.

Parameters:
- WIDTH, 16, accumulator data width in bits (>= 2).
- NUM_ACC, 4, number of accumulators (1..2**SEL_W).
- SEL_W, 2, width of the accumulator select field.
- SHAMT_W, 4, width of the shift-amount field; shift amounts range 0..2**SHAMT_W-1.
- SAT_EN, 0, 0 = inc/dec wrap around; 1 = inc/dec saturate.

Ports:
- clock  in  1  rising-edge system clock
- reset_n  in  1  asynchronous, active-low reset
- sel  in  SEL_W  accumulator select for commands and readout
- write_en  in  1  load datain into acc[sel]
- datain  in  WIDTH  bus data
- alu_to_ac  in  1  load alu_out into acc[sel]
- alu_out  in  WIDTH  ALU result
- inc_en  in  1  increment acc[sel]
- dec_en  in  1  decrement acc[sel]
- clr_en  in  1  clear acc[sel] and its ovf bit
- shift_start  in  1  start serial shift of acc[sel]
- shift_dir  in  1  0 = logical left, 1 = logical right
- shift_amt  in  SHAMT_W  number of 1-bit shift steps
- dataout  out  WIDTH  acc[sel], combinational read
- zero  out  1  dataout == 0
- neg  out  1  dataout[WIDTH-1]
- ovf  out  1  sticky overflow bit of acc[sel]
- busy  out  1  shift FSM not idle
- done  out  1  one-cycle pulse at shift completion

Behaviour:
Reset:
- reset_n low asynchronously forces all accumulators to 0, all ovf bits to 0, the FSM to IDLE, and busy/done to 0.
- Applies mid-shift too; the shift is abandoned and no done pulse is issued.

Command path (FSM in IDLE, shift_start = 0). At most one update per clock edge, to acc[sel] only. Priority:
1. clr_en
2. alu_to_ac
3. write_en
4. inc_en/dec_en

- inc_en and dec_en both high: no change.
- sel >= NUM_ACC: all commands ignored; dataout reads 0; zero = 1; ovf = 0.

Arithmetic (unsigned):
- SAT_EN = 0: inc at all-ones gives 0; dec at 0 gives all-ones. Either wrap sets ovf[sel].
- SAT_EN = 1: inc at all-ones holds all-ones; dec at 0 holds 0. Either clamp sets ovf[sel].
- ovf[sel] is sticky. It is cleared only by clr_en, write_en or alu_to_ac on that accumulator (whichever wins priority), or by reset.

Readout:
- dataout, zero, neg and ovf are combinational from acc[sel]/ovf[sel].
- An update is visible the cycle after the edge that writes it.

Shift FSM, states IDLE -> SHIFT -> DONE -> IDLE:
- shift_start in IDLE latches sel, shift_dir and shift_amt, and overrides every other command in that cycle.
  - shift_amt = N > 0: go to SHIFT.
  - shift_amt = 0: go straight to DONE, accumulator unchanged.
- SHIFT: each cycle, acc[latched sel] shifts by 1 bit with zero fill and the counter decrements. After N shift edges the FSM goes to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Latency: with start sampled at edge 0, the result and done are present after edge N+1; busy is high for N+1 cycles.
- busy = (state != IDLE). While busy, shift_start and all commands are ignored, including commands to other accumulators. The readout mux still follows the live sel.
- Shifts do not change ovf.
- sel latched >= NUM_ACC: the FSM still sequences with correct timing but modifies nothing.

Test Plan:
- Reset/load: reset_n low, then write_en=1, sel=2, datain=0x1234 -> dataout reads 0x1234 at sel=2 and 0x0000 at sel=0; zero=1 at sel=0.
- Priority: same cycle clr_en=0, alu_to_ac=1 (alu_out=0x00FF), write_en=1 (datain=0xAAAA), inc_en=1 -> acc = 0x00FF. Then clr_en=1 with all others high -> acc = 0x0000, ovf = 0.
- Wrap vs saturate:
  - SAT_EN=0: load 0xFFFF, inc -> 0x0000, ovf=1, zero=1; then dec -> 0xFFFF, ovf stays 1, neg=1.
  - SAT_EN=1: load 0xFFFF, inc -> 0xFFFF, ovf=1.
  - inc_en and dec_en together -> no change.
- Shift timing: acc[1]=0x0003, shift_start with sel=1, dir=0, amt=4 -> busy high 5 cycles; done pulses after edge 5; acc[1]=0x0030. A write_en to acc[0] issued while busy is ignored.
- Edge shifts:
  - amt=0 -> done one cycle after start, value unchanged.
  - dir=1, amt=15 on 0x8000 -> 0x0001.
  - shift_start asserted while busy is ignored.
- Reset mid-shift: reset_n low at the 2nd SHIFT cycle -> busy=0, done never pulses, all accumulators = 0; a new shift after release behaves normally.

Source files
------------

// File: rtl/acc_bank_if.sv
`default_nettype none
// ============================================================================
// acc_bank_if : command/readout bundle between control unit and acc_bank
// Revision    : 1.0
// ============================================================================
interface acc_bank_if #(
   parameter int WIDTH   = 16,
   parameter int SEL_W   = 2,
   parameter int SHAMT_W = 4
);
   logic [SEL_W-1:0]   sel;
   logic               write_en;
   logic [WIDTH-1:0]   datain;
   logic               alu_to_ac;
   logic [WIDTH-1:0]   alu_out;
   logic               inc_en;
   logic               dec_en;
   logic               clr_en;
   logic               shift_start;
   logic               shift_dir;
   logic [SHAMT_W-1:0] shift_amt;
   logic [WIDTH-1:0]   dataout;
   logic               zero;
   logic               neg;
   logic               ovf;
   logic               busy;
   logic               done;

   modport master (
      output sel, write_en, datain, alu_to_ac, alu_out, inc_en, dec_en,
             clr_en, shift_start, shift_dir, shift_amt,
      input  dataout, zero, neg, ovf, busy, done
   );

   modport slave (
      input  sel, write_en, datain, alu_to_ac, alu_out, inc_en, dec_en,
             clr_en, shift_start, shift_dir, shift_amt,
      output dataout, zero, neg, ovf, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/acc_bank.sv
`default_nettype none
// ============================================================================
// acc_bank : NUM_ACC accumulators with load/inc/dec/clear and serial shifter
// Revision : 1.0
// ============================================================================
module acc_bank #(
   parameter int WIDTH   = 16,
   parameter int NUM_ACC = 4,
   parameter int SEL_W   = 2,
   parameter int SHAMT_W = 4,
   parameter int SAT_EN  = 0
) (
   input  wire logic   clock,
   input  wire logic   reset_n,
   acc_bank_if.slave   bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] C_ALL_ONES = '1;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [SEL_W-1:0]   r_lat_sel;
   logic               r_lat_dir;
   logic [SHAMT_W-1:0] r_cnt;
   logic               r_done;
   logic               w_start;
   logic               w_cmd_ok;
   logic               w_shift_now;

   logic [WIDTH-1:0]   w_acc [NUM_ACC];
   logic [NUM_ACC-1:0] w_ovf;
   logic [NUM_ACC-1:0] w_hit;
   logic [WIDTH-1:0]   w_rd_data;
   logic               w_rd_ovf;

   assign w_start     = (r_state == S_IDLE) && bus.shift_start;
   assign w_cmd_ok    = (r_state == S_IDLE) && !bus.shift_start;
   assign w_shift_now = (r_state == S_SHIFT);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.shift_start) begin
               w_state_nxt = (bus.shift_amt == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_cnt == SHAMT_W'(1)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // done is registered so it rises on the edge that returns the FSM to IDLE
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_lat_sel <= '0;
         r_lat_dir <= 1'b0;
         r_cnt     <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= (r_state == S_DONE);
         if (w_start) begin
            r_lat_sel <= bus.sel;
            r_lat_dir <= bus.shift_dir;
            r_cnt     <= bus.shift_amt;
         end else if (w_shift_now) begin
            r_cnt <= r_cnt - SHAMT_W'(1);
         end
      end
   end

   for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_acc
      localparam logic [SEL_W-1:0] C_IDX = SEL_W'(gi);

      logic [WIDTH-1:0] r_val;
      logic [WIDTH-1:0] w_val_nxt;
      logic             r_ovf;
      logic             w_ovf_nxt;
      logic             w_cmd_hit;
      logic             w_shift_hit;

      assign w_hit[gi]   = (bus.sel == C_IDX);
      assign w_cmd_hit   = w_cmd_ok && w_hit[gi];
      assign w_shift_hit = w_shift_now && (r_lat_sel == C_IDX);

      always_comb begin
         w_val_nxt = r_val;
         w_ovf_nxt = r_ovf;
         if (w_shift_hit) begin
            w_val_nxt = r_lat_dir ? (r_val >> 1) : (r_val << 1);
         end else if (w_cmd_hit) begin
            if (bus.clr_en) begin
               w_val_nxt = '0;
               w_ovf_nxt = 1'b0;
            end else if (bus.alu_to_ac) begin
               w_val_nxt = bus.alu_out;
               w_ovf_nxt = 1'b0;
            end else if (bus.write_en) begin
               w_val_nxt = bus.datain;
               w_ovf_nxt = 1'b0;
            end else if (bus.inc_en && !bus.dec_en) begin
               if (r_val == C_ALL_ONES) begin
                  w_ovf_nxt = 1'b1;
                  w_val_nxt = (SAT_EN != 0) ? C_ALL_ONES : '0;
               end else begin
                  w_val_nxt = r_val + WIDTH'(1);
               end
            end else if (bus.dec_en && !bus.inc_en) begin
               if (r_val == '0) begin
                  w_ovf_nxt = 1'b1;
                  w_val_nxt = (SAT_EN != 0) ? '0 : C_ALL_ONES;
               end else begin
                  w_val_nxt = r_val - WIDTH'(1);
               end
            end
         end
      end

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            r_val <= '0;
            r_ovf <= 1'b0;
         end else begin
            r_val <= w_val_nxt;
            r_ovf <= w_ovf_nxt;
         end
      end

      assign w_acc[gi] = r_val;
      assign w_ovf[gi] = r_ovf;
   end

   // an out-of-range select matches no slot and therefore reads as zero
   always_comb begin
      w_rd_data = '0;
      w_rd_ovf  = 1'b0;
      for (int i = 0; i < NUM_ACC; i++) begin
         if (w_hit[i]) begin
            w_rd_data = w_acc[i];
            w_rd_ovf  = w_ovf[i];
         end
      end
   end

   assign bus.dataout = w_rd_data;
   assign bus.zero    = (w_rd_data == '0);
   assign bus.neg     = w_rd_data[WIDTH-1];
   assign bus.ovf     = w_rd_ovf;
   assign bus.busy    = (r_state != S_IDLE);
   assign bus.done    = r_done;
endmodule
`default_nettype wire

// File: tb/tb_acc_bank.sv
`default_nettype none
// ============================================================================
// tb_acc_bank : wrap (4 acc) and saturate (3 acc) banks against a reference
// Revision    : 1.0
// ============================================================================
module tb_acc_bank;
   localparam int W  = 16;
   localparam int SW = 2;
   localparam int SA = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [SW-1:0] sel;
   logic          write_en, alu_to_ac, inc_en, dec_en, clr_en;
   logic          shift_start, shift_dir;
   logic [W-1:0]  datain, alu_out;
   logic [SA-1:0] shift_amt;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   acc_bank_if #(.WIDTH(W), .SEL_W(SW), .SHAMT_W(SA)) bus0 ();
   acc_bank_if #(.WIDTH(W), .SEL_W(SW), .SHAMT_W(SA)) bus1 ();

   assign bus0.sel = sel;            assign bus1.sel = sel;
   assign bus0.write_en = write_en;  assign bus1.write_en = write_en;
   assign bus0.datain = datain;      assign bus1.datain = datain;
   assign bus0.alu_to_ac = alu_to_ac; assign bus1.alu_to_ac = alu_to_ac;
   assign bus0.alu_out = alu_out;    assign bus1.alu_out = alu_out;
   assign bus0.inc_en = inc_en;      assign bus1.inc_en = inc_en;
   assign bus0.dec_en = dec_en;      assign bus1.dec_en = dec_en;
   assign bus0.clr_en = clr_en;      assign bus1.clr_en = clr_en;
   assign bus0.shift_start = shift_start; assign bus1.shift_start = shift_start;
   assign bus0.shift_dir = shift_dir; assign bus1.shift_dir = shift_dir;
   assign bus0.shift_amt = shift_amt; assign bus1.shift_amt = shift_amt;

   acc_bank #(.WIDTH(W), .NUM_ACC(4), .SEL_W(SW), .SHAMT_W(SA), .SAT_EN(0)) u_wrap (
      .clock(clock), .reset_n(reset_n), .bus(bus0));
   acc_bank #(.WIDTH(W), .NUM_ACC(3), .SEL_W(SW), .SHAMT_W(SA), .SAT_EN(1)) u_sat (
      .clock(clock), .reset_n(reset_n), .bus(bus1));

   always #5 clock = ~clock;

   // ---------------- reference model (index 0 = wrap bank, 1 = saturate bank)
   logic [W-1:0] m_acc [2][4];
   logic         m_ovf [2][4];
   int           m_busy_left, m_shifts_left;
   logic [SW-1:0] m_tsel;
   logic         m_tdir, m_done;

   function automatic int nacc_of(input int s);
      return (s == 0) ? 4 : 3;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 4; a++) begin
            m_acc[s][a] = '0;
            m_ovf[s][a] = 1'b0;
         end
      m_busy_left = 0; m_shifts_left = 0; m_done = 1'b0;
      m_tsel = '0; m_tdir = 1'b0;
   endtask

   task automatic apply_cmd(input int s);
      int v;
      if (clr_en) begin
         m_acc[s][sel] = '0; m_ovf[s][sel] = 1'b0;
      end else if (alu_to_ac) begin
         m_acc[s][sel] = alu_out; m_ovf[s][sel] = 1'b0;
      end else if (write_en) begin
         m_acc[s][sel] = datain; m_ovf[s][sel] = 1'b0;
      end else if (inc_en != dec_en) begin
         v = int'(m_acc[s][sel]) + (inc_en ? 1 : -1);
         if (v < 0 || v > 65535) begin
            m_ovf[s][sel] = 1'b1;
            if (s == 1) v = (v < 0) ? 0 : 65535;
         end
         m_acc[s][sel] = W'(v);
      end
   endtask

   task automatic model_edge();
      m_done = 1'b0;
      if (m_busy_left > 0) begin
         if (m_shifts_left > 0) begin
            for (int s = 0; s < 2; s++)
               if (int'(m_tsel) < nacc_of(s))
                  m_acc[s][m_tsel] = m_tdir ? (m_acc[s][m_tsel] >> 1) : (m_acc[s][m_tsel] << 1);
            m_shifts_left--;
         end
         m_busy_left--;
         if (m_busy_left == 0) m_done = 1'b1;
      end else if (shift_start) begin
         m_tsel = sel; m_tdir = shift_dir;
         m_shifts_left = int'(shift_amt);
         m_busy_left = int'(shift_amt) + 1;
      end else begin
         for (int s = 0; s < 2; s++)
            if (int'(sel) < nacc_of(s)) apply_cmd(s);
      end
   endtask

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) model_reset();
      else model_edge();
   end

   function automatic logic [20:0] expect_vec(input int s);
      logic [W-1:0] d;
      logic o;
      d = '0; o = 1'b0;
      if (int'(sel) < nacc_of(s)) begin
         d = m_acc[s][sel]; o = m_ovf[s][sel];
      end
      return {d, d == '0, d[W-1], o, m_busy_left > 0, m_done};
   endfunction

   always @(negedge clock) begin
      if (cmp_en) begin
         logic [20:0] act, exp;
         for (int s = 0; s < 2; s++) begin
            act = (s == 0) ? {bus0.dataout, bus0.zero, bus0.neg, bus0.ovf, bus0.busy, bus0.done}
                           : {bus1.dataout, bus1.zero, bus1.neg, bus1.ovf, bus1.busy, bus1.done};
            exp = expect_vec(s);
            checks++;
            if (act !== exp) begin
               errors++;
               $display("FAIL outputs bank%0d t=%0t sel=%0d got %h want %h", s, $time, sel, act, exp);
            end
         end
      end
   end

   // ---------------- stimulus helpers
   task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic idle();
      write_en = 0; alu_to_ac = 0; inc_en = 0; dec_en = 0; clr_en = 0;
      shift_start = 0; shift_dir = 0; shift_amt = '0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // waits out a busy period; inject_at>=0 drives a command at that busy cycle
   task automatic wait_busy(input int inject_at, input bit inj_shift, output int bcnt);
      bcnt = 0;
      while (bus0.busy === 1'b1 && bcnt < 40) begin
         idle();
         if (bcnt == inject_at) begin
            if (inj_shift) begin
               shift_start = 1; shift_amt = 4'd2; shift_dir = 0;
            end else begin
               sel = 2'd0; write_en = 1; datain = 16'h5555;
            end
         end
         step();
         bcnt++;
      end
      idle();
   endtask

   initial begin
      int bcnt;
      int r;
      model_reset();
      idle(); sel = '0; datain = '0; alu_out = '0;
      step(); cmp_en = 1'b1; step();
      check_lit("rst_data", 32'(bus0.dataout), 32'h0);
      check_lit("rst_zero", 32'(bus0.zero), 32'h1);
      check_lit("rst_busy", 32'(bus0.busy), 32'h0);
      reset_n = 1; step();

      sel = 2'd2; write_en = 1; datain = 16'h1234; step(); idle();
      check_lit("load_sel2", 32'(bus0.dataout), 32'h1234);
      check_lit("load_sel2_sat", 32'(bus1.dataout), 32'h1234);
      sel = 2'd0; #1;
      check_lit("load_sel0", 32'(bus0.dataout), 32'h0);
      check_lit("zero_sel0", 32'(bus0.zero), 32'h1);

      sel = 2'd3; write_en = 1; datain = 16'h4321; step(); idle();
      check_lit("load_sel3", 32'(bus0.dataout), 32'h4321);
      check_lit("bad_sel_data", 32'(bus1.dataout), 32'h0);
      check_lit("bad_sel_zero", 32'(bus1.zero), 32'h1);

      sel = 2'd1; alu_to_ac = 1; alu_out = 16'h00FF; write_en = 1; datain = 16'hAAAA; inc_en = 1;
      step(); idle();
      check_lit("prio_alu", 32'(bus0.dataout), 32'h00FF);
      clr_en = 1; alu_to_ac = 1; write_en = 1; inc_en = 1; dec_en = 1;
      step(); idle();
      check_lit("prio_clr", 32'(bus0.dataout), 32'h0);
      check_lit("prio_clr_ovf", 32'(bus0.ovf), 32'h0);

      sel = 2'd0; write_en = 1; datain = 16'hFFFF; step(); idle();
      inc_en = 1; step(); idle();
      check_lit("wrap_inc", 32'(bus0.dataout), 32'h0);
      check_lit("wrap_inc_ovf", 32'(bus0.ovf), 32'h1);
      check_lit("wrap_inc_zero", 32'(bus0.zero), 32'h1);
      check_lit("sat_inc", 32'(bus1.dataout), 32'hFFFF);
      check_lit("sat_inc_ovf", 32'(bus1.ovf), 32'h1);
      dec_en = 1; step(); idle();
      check_lit("wrap_dec", 32'(bus0.dataout), 32'hFFFF);
      check_lit("wrap_dec_ovf", 32'(bus0.ovf), 32'h1);
      check_lit("wrap_dec_neg", 32'(bus0.neg), 32'h1);
      check_lit("sat_dec_sticky", 32'(bus1.dataout), 32'hFFFE);
      inc_en = 1; dec_en = 1; step(); idle();
      check_lit("incdec_hold", 32'(bus0.dataout), 32'hFFFF);
      write_en = 1; datain = 16'h0000; step(); idle();
      check_lit("write_clears_ovf", 32'(bus0.ovf), 32'h0);
      dec_en = 1; step(); idle();
      check_lit("wrap_dec0", 32'(bus0.dataout), 32'hFFFF);
      check_lit("sat_dec0", 32'(bus1.dataout), 32'h0);
      check_lit("sat_dec0_ovf", 32'(bus1.ovf), 32'h1);

      sel = 2'd1; write_en = 1; datain = 16'h0003; step(); idle();
      shift_start = 1; shift_dir = 0; shift_amt = 4'd4; step();
      wait_busy(1, 1'b0, bcnt);
      check_lit("shift4_busy_cycles", 32'(bcnt), 32'd5);
      check_lit("shift4_done", 32'(bus0.done), 32'h1);
      sel = 2'd1; #1;
      check_lit("shift4_result", 32'(bus0.dataout), 32'h0030);
      sel = 2'd0; #1;
      check_lit("busy_write_ignored", 32'(bus0.dataout), 32'hFFFF);
      step();
      check_lit("done_one_cycle", 32'(bus0.done), 32'h0);

      sel = 2'd1; shift_start = 1; shift_amt = 4'd0; step(); idle();
      check_lit("amt0_busy", 32'(bus0.busy), 32'h1);
      check_lit("amt0_nodone", 32'(bus0.done), 32'h0);
      step();
      check_lit("amt0_done", 32'(bus0.done), 32'h1);
      check_lit("amt0_value", 32'(bus0.dataout), 32'h0030);

      sel = 2'd2; write_en = 1; datain = 16'h8000; step(); idle();
      shift_start = 1; shift_dir = 1; shift_amt = 4'd15; step();
      wait_busy(3, 1'b1, bcnt);
      check_lit("shift15_busy_cycles", 32'(bcnt), 32'd16);
      check_lit("shift15_result", 32'(bus0.dataout), 32'h0001);
      check_lit("shift15_done", 32'(bus0.done), 32'h1);
      step();

      sel = 2'd2; shift_start = 1; shift_dir = 0; shift_amt = 4'd8; step(); idle();
      step();
      reset_n = 0; #1;
      check_lit("midrst_busy", 32'(bus0.busy), 32'h0);
      for (int i = 0; i < 4; i++) begin
         sel = SW'(i); #1;
         check_lit("midrst_acc", 32'(bus0.dataout), 32'h0);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         check_lit("midrst_nodone", 32'(bus0.done), 32'h0);
      end
      reset_n = 1; step();
      sel = 2'd3; write_en = 1; datain = 16'h0101; step(); idle();
      shift_start = 1; shift_dir = 1; shift_amt = 4'd1; step(); idle();
      check_lit("post_rst_busy", 32'(bus0.busy), 32'h1);
      step(); step();
      check_lit("post_rst_done", 32'(bus0.done), 32'h1);
      check_lit("post_rst_value", 32'(bus0.dataout), 32'h0080);

      for (int n = 0; n < 1500; n++) begin
         idle();
         sel = SW'($urandom_range(0, 3));
         r = $urandom_range(0, 99);
         case ($urandom_range(0, 3))
            0: datain = 16'hFFFF;
            1: datain = 16'h0000;
            default: datain = W'($urandom);
         endcase
         alu_out = W'($urandom);
         clr_en = (r < 5);
         alu_to_ac = ($urandom_range(0, 9) == 0);
         write_en = ($urandom_range(0, 6) == 0);
         inc_en = ($urandom_range(0, 2) == 0);
         dec_en = ($urandom_range(0, 2) == 0);
         shift_start = ($urandom_range(0, 11) == 0);
         shift_dir = 1'($urandom);
         shift_amt = SA'($urandom_range(0, 15));
         if ($urandom_range(0, 399) == 0) reset_n = 0;
         step();
         reset_n = 1;
      end

      idle();
      repeat (20) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
